// File: rtl/rcv_cmd_if.sv
// Handshake bundle between rcv_cmd and its UART receiver, UART transmitter and command consumer.
// The master modport is the rcv_cmd side; the slave modport is the surrounding logic.
interface rcv_cmd_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        timeout;
    logic        send_resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;

    modport master (
        input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, timeout, trmt, tx_data, resp_sent
    );

    modport slave (
        output rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, timeout, trmt, tx_data, resp_sent
    );
endinterface

// File: rtl/rcv_cmd.sv
// Assembles three UART bytes into a 24-bit command with an inter-byte idle timeout,
// and sends a single acknowledge byte on request through an independent response FSM.
module rcv_cmd #(
    parameter int unsigned TO_CYC    = 50000,
    parameter logic [7:0]  RESP_BYTE = 8'h0A
) (
    input  logic           clk,
    input  logic           rst,
    rcv_cmd_if.master      bus
);
    localparam int unsigned CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC - 1);

    typedef enum logic [1:0] {HIGH, MID, LOW} rx_state_t;
    typedef enum logic {R_IDLE, R_BUSY} resp_state_t;

    rx_state_t        rx_state, rx_nxt;
    resp_state_t      r_state, r_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [15:0]      shadow, shadow_nxt;
    logic [23:0]      cmd, cmd_nxt;
    logic             cmd_rdy, cmd_rdy_nxt;
    logic             timeout, timeout_nxt;
    logic             trmt, trmt_nxt;
    logic             resp_sent, resp_sent_nxt;

    assign bus.clr_rx_rdy = bus.rx_rdy & ~rst;
    assign bus.tx_data    = RESP_BYTE;
    assign bus.cmd        = cmd;
    assign bus.cmd_rdy    = cmd_rdy;
    assign bus.timeout    = timeout;
    assign bus.trmt       = trmt;
    assign bus.resp_sent  = resp_sent;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rx_nxt      = rx_state;
        shadow_nxt  = shadow;
        cnt_nxt     = cnt;
        cmd_nxt     = cmd;
        cmd_rdy_nxt = cmd_rdy & ~bus.clr_cmd_rdy;
        timeout_nxt = 1'b0;
        unique case (rx_state)
            HIGH: begin
                cnt_nxt = '0;
                if (bus.rx_rdy) begin
                    shadow_nxt[15:8] = bus.rx_data;
                    cmd_rdy_nxt      = 1'b0;
                    rx_nxt           = MID;
                end
            end
            MID, LOW: begin
                if (bus.rx_rdy) begin
                    cnt_nxt = '0;
                    if (rx_state == MID) begin
                        shadow_nxt[7:0] = bus.rx_data;
                        rx_nxt          = LOW;
                    end else begin
                        // Set wins over a simultaneous clr_cmd_rdy.
                        cmd_nxt     = {shadow, bus.rx_data};
                        cmd_rdy_nxt = 1'b1;
                        rx_nxt      = HIGH;
                    end
                end else if (cnt == CNT_MAX) begin
                    rx_nxt      = HIGH;
                    shadow_nxt  = '0;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: rx_nxt = HIGH;
        endcase
    end

    always_comb begin
        r_nxt         = r_state;
        trmt_nxt      = 1'b0;
        resp_sent_nxt = 1'b0;
        unique case (r_state)
            R_IDLE: if (bus.send_resp) begin
                r_nxt    = R_BUSY;
                trmt_nxt = 1'b1;
            end
            R_BUSY: if (bus.tx_done) begin
                r_nxt         = R_IDLE;
                resp_sent_nxt = 1'b1;
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= HIGH;
            r_state   <= R_IDLE;
            cnt       <= '0;
            shadow    <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
            timeout   <= 1'b0;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            rx_state  <= rx_nxt;
            r_state   <= r_nxt;
            cnt       <= cnt_nxt;
            shadow    <= shadow_nxt;
            cmd       <= cmd_nxt;
            cmd_rdy   <= cmd_rdy_nxt;
            timeout   <= timeout_nxt;
            trmt      <= trmt_nxt;
            resp_sent <= resp_sent_nxt;
        end
    end
endmodule

// File: tb/tb_rcv_cmd.sv
// Self-checking bench for rcv_cmd: fixed vector table, directed corner sequences and
// randomized traffic compared against a queue-based model of the command/response rules.
module tb_rcv_cmd;
    localparam int unsigned TO_CYC = 12;

    logic clk = 1'b0;
    logic rst;
    rcv_cmd_if bus();

    rcv_cmd #(.TO_CYC(TO_CYC), .RESP_BYTE(8'h0A)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bytes of the pending command, silent cycles since the last byte.
    logic [7:0]  m_q[$];
    int          m_idle;
    logic [23:0] m_cmd;
    logic        m_cmd_rdy;
    logic        m_busy;
    logic        m_timeout, m_trmt, m_resp_sent;

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        c;
        logic        s;
        logic        t;
        logic [23:0] e_cmd;
        logic        e_rdy;
        logic        e_to;
        logic        e_trmt;
        logic        e_rs;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d,
                              input logic c, input logic s, input logic t);
        m_timeout   = 1'b0;
        m_trmt      = 1'b0;
        m_resp_sent = 1'b0;
        if (r) begin
            m_q.delete();
            m_idle    = 0;
            m_cmd     = '0;
            m_cmd_rdy = 1'b0;
            m_busy    = 1'b0;
        end else begin
            if (c) m_cmd_rdy = 1'b0;
            if (v) begin
                m_q.push_back(d);
                m_idle = 0;
                if (m_q.size() == 1) m_cmd_rdy = 1'b0;
                if (m_q.size() == 3) begin
                    m_cmd     = {m_q[0], m_q[1], m_q[2]};
                    m_cmd_rdy = 1'b1;
                    m_q.delete();
                end
            end else if (m_q.size() != 0) begin
                m_idle++;
                if (m_idle >= TO_CYC) begin
                    m_q.delete();
                    m_idle    = 0;
                    m_timeout = 1'b1;
                end
            end
            if (!m_busy && s) begin
                m_busy = 1'b1;
                m_trmt = 1'b1;
            end else if (m_busy && t) begin
                m_busy      = 1'b0;
                m_resp_sent = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, check the combinational outputs, clock, then check registered outputs.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                         input logic c, input logic s, input logic t);
        rst             = r;
        bus.rx_rdy      = v;
        bus.rx_data     = d;
        bus.clr_cmd_rdy = c;
        bus.send_resp   = s;
        bus.tx_done     = t;
        #1;
        check("clr_rx_rdy", bus.clr_rx_rdy, v & ~r);
        check("tx_data", bus.tx_data, 8'h0A);
        model_step(r, v, d, c, s, t);
        @(posedge clk);
        #1;
        check("cmd", bus.cmd, m_cmd);
        check("cmd_rdy", bus.cmd_rdy, m_cmd_rdy);
        check("timeout", bus.timeout, m_timeout);
        check("trmt", bus.trmt, m_trmt);
        check("resp_sent", bus.resp_sent, m_resp_sent);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic byte_in(input logic [7:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[$];
    int   to_count;
    int   to_at;

    initial begin
        rst = 1'b1;
        bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b0; bus.tx_done = 1'b0;
        @(posedge clk);
        #1;

        //            r  v  d      c  s  t  cmd         rdy to trmt rs
        vecs.push_back('{1, 0, 8'h00, 0, 0, 0, 24'h000000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h12, 0, 0, 0, 24'h000000, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 24'h000000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h34, 0, 0, 0, 24'h000000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h56, 0, 0, 0, 24'h123456, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 24'h123456, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 1, 0, 24'h123456, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 1, 0, 24'h123456, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 24'h123456, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 1, 24'h123456, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 8'hFF, 0, 0, 0, 24'h123456, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 8'hEE, 0, 1, 0, 24'h000000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h11, 0, 0, 0, 24'h000000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h22, 0, 0, 0, 24'h000000, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h33, 1, 0, 0, 24'h112233, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 8'h44, 0, 0, 0, 24'h112233, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 24'h112233, 0, 0, 0, 0});
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].s, vecs[i].t);
            check($sformatf("vec%0d_cmd", i), bus.cmd, vecs[i].e_cmd);
            check($sformatf("vec%0d_rdy", i), bus.cmd_rdy, vecs[i].e_rdy);
            check($sformatf("vec%0d_to", i), bus.timeout, vecs[i].e_to);
            check($sformatf("vec%0d_trmt", i), bus.trmt, vecs[i].e_trmt);
            check($sformatf("vec%0d_rs", i), bus.resp_sent, vecs[i].e_rs);
        end

        // Bytes ten cycles apart.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        byte_in(8'h12); idle(9);
        byte_in(8'h34); idle(9);
        byte_in(8'h56);
        check("spaced_cmd", bus.cmd, 24'h123456);
        check("spaced_rdy", bus.cmd_rdy, 1'b1);

        // Partial command timed out, then a fresh command.
        byte_in(8'hAA); byte_in(8'hBB);
        to_count = 0;
        to_at    = -1;
        for (int i = 1; i <= TO_CYC + 3; i++) begin
            idle(1);
            if (bus.timeout === 1'b1) begin
                to_count++;
                to_at = i;
            end
        end
        check("timeout_count", to_count, 1);
        check("timeout_cycle", to_at, TO_CYC);
        check("timeout_cmd_kept", bus.cmd, 24'h123456);
        byte_in(8'h01); byte_in(8'h02); byte_in(8'h03);
        check("after_to_cmd", bus.cmd, 24'h010203);

        // Byte arriving exactly on the last idle cycle, in LOW then in MID.
        byte_in(8'h77); byte_in(8'h88); idle(TO_CYC - 1);
        byte_in(8'h99);
        check("edge_low_cmd", bus.cmd, 24'h778899);
        check("edge_low_rdy", bus.cmd_rdy, 1'b1);
        check("edge_low_to", bus.timeout, 1'b0);
        byte_in(8'h5A); idle(TO_CYC - 1);
        byte_in(8'h5B);
        check("edge_mid_to", bus.timeout, 1'b0);
        byte_in(8'h5C);
        check("edge_mid_cmd", bus.cmd, 24'h5A5B5C);

        // Third byte with clr_cmd_rdy, then clr_cmd_rdy alone.
        byte_in(8'hC1); byte_in(8'hC2);
        cycle(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        check("set_wins_rdy", bus.cmd_rdy, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("clr_rdy", bus.cmd_rdy, 1'b0);

        // Randomized traffic with varying byte density to reach timeouts.
        for (int seg = 0; seg < 60; seg++) begin
            int unsigned dens;
            dens = $urandom_range(1, 10);
            for (int i = 0; i < 50; i++) begin
                cycle(($urandom_range(0, 299) == 0),
                      ($urandom_range(0, 99) < dens * 5),
                      8'($urandom),
                      ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 5) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rcv_cmd.md
RCV_CMD -- requirements
Module: rcv_cmd

Interface
REQ-001 Parameter TO_CYC, default 50000: max idle cycles allowed between bytes of one command.
REQ-002 Parameter RESP_BYTE, default 8'h0A: byte transmitted as acknowledge.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rx_rdy  in  1  UART receiver holds a valid byte.
REQ-006 rx_data  in  8  received byte, valid while rx_rdy=1.
REQ-007 clr_rx_rdy  out  1  consumes the UART byte.
REQ-008 cmd  out  24  last complete command, {byte0,byte1,byte2}.
REQ-009 cmd_rdy  out  1  cmd valid and unconsumed.
REQ-010 clr_cmd_rdy  in  1  consumer has taken cmd.
REQ-011 timeout  out  1  one-cycle pulse: partial command discarded.
REQ-012 send_resp  in  1  request to transmit RESP_BYTE.
REQ-013 trmt  out  1  one-cycle start pulse to UART transmitter.
REQ-014 tx_data  out  8  byte to transmit; constant RESP_BYTE.
REQ-015 tx_done  in  1  UART transmitter finished current byte.
REQ-016 resp_sent  out  1  one-cycle pulse: acknowledge fully transmitted.

Function
REQ-017 Receive FSM SHALL have states HIGH, MID, LOW, which wait for byte0, byte1 and byte2 respectively.
REQ-018 clr_rx_rdy SHALL be combinational and equal rx_rdy in every state; it is 0 while rst=1.
REQ-019 A byte accepted in HIGH goes to shadow[15:8], FSM->MID, and cmd_rdy clears on the next edge.
REQ-020 A byte accepted in MID goes to shadow[7:0], FSM->LOW.
REQ-021 A byte accepted in LOW loads cmd={shadow,rx_data} atomically; cmd_rdy=1 on the next edge; FSM->HIGH.
REQ-022 cmd SHALL change only per REQ-021 or reset; partial commands never alter cmd.
REQ-023 cmd_rdy clears the edge after clr_cmd_rdy=1; set (REQ-021) wins over a simultaneous clr_cmd_rdy.
REQ-024 Idle counter SHALL clear on every accepted byte and in HIGH; it increments each cycle in MID/LOW without rx_rdy; it saturates at TO_CYC-1.
REQ-025 In MID/LOW, counter==TO_CYC-1 with rx_rdy=0 -> FSM->HIGH, shadow discarded, timeout=1 for exactly that next cycle, cmd/cmd_rdy untouched.
REQ-026 rx_rdy in the same cycle as the timeout condition -> byte accepted, no timeout.
REQ-027 Response FSM SHALL have states R_IDLE, R_BUSY, independent of the receive FSM.
REQ-028 R_IDLE with send_resp=1 -> trmt=1 on the next cycle only, state->R_BUSY.
REQ-029 R_BUSY with tx_done=1 -> R_IDLE, resp_sent=1 for the next cycle only.
REQ-030 send_resp in R_BUSY SHALL be ignored (not queued); tx_done in R_IDLE SHALL be ignored.
REQ-031 Counter width SHALL be clog2(TO_CYC); no overflow wrap permitted.

Reset
REQ-032 rst=1 at an edge -> FSM=HIGH, R_IDLE, counter=0, shadow=0, cmd=24'h000000, cmd_rdy=0, timeout=0, trmt=0, resp_sent=0.
REQ-033 Reset mid-command or mid-transmit SHALL discard all progress; the first byte after reset is treated as byte0.
REQ-034 tx_data SHALL equal RESP_BYTE during and after reset.

Verification
REQ-035 Bytes 8'h12, 8'h34, 8'h56 each with a one-cycle rx_rdy, 10 cycles apart -> cmd=24'h123456, cmd_rdy=1 one cycle after the third, clr_rx_rdy=1 on each rx_rdy cycle.
REQ-036 8'hAA, 8'hBB, then silence for TO_CYC cycles -> timeout pulse once, cmd keeps its prior value, next bytes 01/02/03 -> cmd=24'h010203.
REQ-037 Third byte and clr_cmd_rdy in the same cycle -> cmd_rdy=1 afterwards; clr_cmd_rdy alone next cycle -> cmd_rdy=0.
REQ-038 send_resp pulse -> trmt high exactly one cycle with tx_data=8'h0A; send_resp again before tx_done -> no second trmt; tx_done -> resp_sent one cycle.
REQ-039 rst=1 after byte0 8'hFF -> outputs at reset values; bytes 11/22/33 -> cmd=24'h112233.
REQ-040 rx_rdy arriving exactly when counter=TO_CYC-1 in LOW -> byte accepted, cmd_rdy=1, no timeout.
